// File: rtl/reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reset_ctrl
//  Description : Reset controller for the RISC-V core. It takes the raw board
//                reset, synchronizes its release and stretches it, then watches
//                the running core with a heartbeat watchdog and halt detection.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SYNC_STAGES   flops in the reset-deassertion synchronizer (>=2)
//    RESET_CYCLES  cycles core_rst is held after synchronized release (>=1)
//    TIMEOUT       maximum cycles between heartbeats while running (>=2)
//    CNT_W         width of cycle_count and of the internal counters
//  Ports
//    clk          in   1      system clock
//    rst_n        in   1      asynchronous, active-low board reset
//    sw_rst_req   in   1      synchronous soft-reset request (1-cycle pulse)
//    heartbeat    in   1      core progress pulse
//    halt         in   1      core reports normal program end
//    core_rst     out  1      active-high core reset; async assert, sync release
//    running      out  1      state == RUN
//    halted       out  1      state == HALTED
//    timeout      out  1      state == TIMEDOUT
//    state        out  2      ASSERT=0, RUN=1, HALTED=2, TIMEDOUT=3
//    cycle_count  out  CNT_W  cycles spent in RUN since last reset (saturating)
// ============================================================================
module reset_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 5,
    parameter int TIMEOUT      = 100000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_req,
    input  logic             heartbeat,
    input  logic             halt,
    output logic             core_rst,
    output logic             running,
    output logic             halted,
    output logic             timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALTED   = 2'd2,
        ST_TIMEDOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_WDOG_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    // ------------------------------------------------------------------------
    // Reset-release synchronizer: cleared asynchronously, fills with ones.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_srst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_srst_n = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] r_wdog;
    logic [CNT_W-1:0] w_wdog_nxt;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] w_cyc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ASSERT;
            r_hold  <= '0;
            r_wdog  <= '0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_wdog  <= w_wdog_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_wdog_nxt  = r_wdog;
        w_cyc_nxt   = r_cyc;

        case (r_state)
            ST_ASSERT: begin
                // Soft reset requests are meaningless here: the core is
                // already held in reset and the hold count keeps running.
                if (w_srst_n) begin
                    if (r_hold == C_HOLD_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // Every cycle spent in RUN is counted, including the cycle in
                // which the core leaves RUN, so the frozen value equals the
                // number of RUN cycles.
                if (r_cyc != C_CNT_MAX) begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
                w_wdog_nxt = heartbeat ? '0 : (r_wdog + 1'b1);

                if (sw_rst_req) begin
                    w_state_nxt = ST_ASSERT;
                    w_hold_nxt  = '0;
                    w_wdog_nxt  = '0;
                    w_cyc_nxt   = '0;
                end else if (halt) begin
                    w_state_nxt = ST_HALTED;
                end else if ((r_wdog == C_WDOG_LAST) && !heartbeat) begin
                    w_state_nxt = ST_TIMEDOUT;
                end
            end

            ST_HALTED, ST_TIMEDOUT: begin
                // Terminal states: counters frozen until a soft reset.
                if (sw_rst_req) begin
                    w_state_nxt = ST_ASSERT;
                    w_hold_nxt  = '0;
                    w_wdog_nxt  = '0;
                    w_cyc_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_ASSERT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded straight from the state register, so core_rst asserts
    // asynchronously with rst_n and releases on a clock edge.
    // ------------------------------------------------------------------------
    assign core_rst    = (r_state == ST_ASSERT);
    assign running     = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALTED);
    assign timeout     = (r_state == ST_TIMEDOUT);
    assign state       = r_state;
    assign cycle_count = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_ctrl
//  Description : Directed self-checking bench for reset_ctrl (TIMEOUT=16,
//                other parameters at their defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sw_rst_req;
    logic        heartbeat;
    logic        halt;
    logic        core_rst;
    logic        running;
    logic        halted;
    logic        timeout;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int n_chk;
    int n_fail;

    reset_ctrl #(
        .SYNC_STAGES  (2),
        .RESET_CYCLES (5),
        .TIMEOUT      (16),
        .CNT_W        (32)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (sw_rst_req),
        .heartbeat   (heartbeat),
        .halt        (halt),
        .core_rst    (core_rst),
        .running     (running),
        .halted      (halted),
        .timeout     (timeout),
        .state       (state),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release rst_n now; core_rst must stay high for 6 edges and drop on edge 7.
    task automatic por_release(input string tag);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) begin
                chk($sformatf("%s_hold_e%0d", tag, e), 64'(core_rst), 64'd1);
            end else begin
                chk($sformatf("%s_release", tag), 64'(core_rst), 64'd0);
                chk($sformatf("%s_running", tag), 64'(running), 64'd1);
                chk($sformatf("%s_state", tag), 64'(state), 64'd1);
                chk($sformatf("%s_cyc0", tag), 64'(cycle_count), 64'd0);
            end
        end
    endtask

    // Pulse sw_rst_req for one cycle; core_rst high on that edge, held 5 cycles.
    task automatic sw_reset(input string tag);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk($sformatf("%s_assert", tag), 64'(core_rst), 64'd1);
        chk($sformatf("%s_state0", tag), 64'(state), 64'd0);
        chk($sformatf("%s_cyc_clr", tag), 64'(cycle_count), 64'd0);
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e < 5) begin
                chk($sformatf("%s_hold_e%0d", tag, e), 64'(core_rst), 64'd1);
            end else begin
                chk($sformatf("%s_release", tag), 64'(core_rst), 64'd0);
                chk($sformatf("%s_running", tag), 64'(running), 64'd1);
                chk($sformatf("%s_cyc0", tag), 64'(cycle_count), 64'd0);
                chk($sformatf("%s_timeout0", tag), 64'(timeout), 64'd0);
            end
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        heartbeat  = 1'b0;
        halt       = 1'b0;

        // ---- Test 1: reset state before any clock edge, then power-on release
        #2;
        chk("t1_rst_core_rst", 64'(core_rst), 64'd1);
        chk("t1_rst_state", 64'(state), 64'd0);
        chk("t1_rst_flags", {61'd0, running, halted, timeout}, 64'd0);
        chk("t1_rst_cyc", 64'(cycle_count), 64'd0);
        tick();
        tick();
        por_release("t1");

        // ---- Test 2: heartbeat every 10 cycles keeps watchdog quiet
        for (int i = 0; i < 100; i++) begin
            heartbeat = ((i % 10) == 9);
            tick();
            chk($sformatf("t2_quiet_%0d", i), 64'(timeout), 64'd0);
        end
        heartbeat = 1'b0;
        chk("t2_cyc100", 64'(cycle_count), 64'd100);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                chk($sformatf("t2_pre_expiry_%0d", k), 64'(timeout), 64'd0);
            end else begin
                chk("t2_timeout", 64'(timeout), 64'd1);
                chk("t2_state", 64'(state), 64'd3);
                chk("t2_not_running", 64'(running), 64'd0);
                chk("t2_cyc_frozen", 64'(cycle_count), 64'd116);
            end
        end
        tick();
        chk("t2_sticky", 64'(timeout), 64'd1);

        // ---- Test 5: soft reset out of TIMEDOUT
        sw_reset("t5");

        // ---- Test 3: halt during the 40th RUN cycle
        for (int i = 0; i < 39; i++) begin
            heartbeat = ((i % 10) == 9);
            tick();
        end
        heartbeat = 1'b0;
        chk("t3_cyc39", 64'(cycle_count), 64'd39);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t3_halted", 64'(halted), 64'd1);
        chk("t3_state", 64'(state), 64'd2);
        chk("t3_cyc40", 64'(cycle_count), 64'd40);
        for (int i = 0; i < 30; i++) begin
            heartbeat = (i % 3) == 0;
            halt      = (i % 5) == 0;
            tick();
        end
        heartbeat = 1'b0;
        halt      = 1'b0;
        chk("t3_still_halted", 64'(halted), 64'd1);
        chk("t3_no_timeout", 64'(timeout), 64'd0);
        chk("t3_cyc_frozen", 64'(cycle_count), 64'd40);

        // ---- Test 4: heartbeat at expiry, then halt at expiry
        sw_reset("t4r");
        for (int k = 1; k <= 15; k++) begin
            tick();
        end
        chk("t4_pre_hb_running", 64'(running), 64'd1);
        heartbeat = 1'b1;               // watchdog is at TIMEOUT-1 this cycle
        tick();
        heartbeat = 1'b0;
        chk("t4_hb_saves", 64'(timeout), 64'd0);
        chk("t4_hb_running", 64'(running), 64'd1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("t4_restart_%0d", k), 64'(running), 64'd1);
        end
        halt = 1'b1;                    // watchdog is at TIMEOUT-1 again
        tick();
        halt = 1'b0;
        chk("t4_halt_wins", 64'(halted), 64'd1);
        chk("t4_no_timeout", 64'(timeout), 64'd0);
        chk("t4_cyc", 64'(cycle_count), 64'd32);

        // ---- Test 6: asynchronous rst_n drop mid-RUN
        sw_reset("t6r");
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("t6_cyc5", 64'(cycle_count), 64'd5);
        #2;
        rst_n = 1'b0;                   // between clock edges
        #1;
        chk("t6_async_core_rst", 64'(core_rst), 64'd1);
        chk("t6_async_state", 64'(state), 64'd0);
        chk("t6_async_running", 64'(running), 64'd0);
        chk("t6_async_cyc", 64'(cycle_count), 64'd0);
        tick();
        tick();
        chk("t6_held", 64'(core_rst), 64'd1);
        por_release("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
